// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle magnitude comparator that walks the operands
// CHUNK bits at a time from the MSB end and stops at the first differing chunk.
//
// Parameters
//   WIDTH      operand width in bits (must be a multiple of CHUNK)
//   CHUNK      bits compared per cycle
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      request a compare; only accepted while idle
//   A, B       operands, sampled when start is accepted
//   is_signed  1 = two's-complement compare, 0 = unsigned; sampled with A/B
//   busy       high while the compare is in progress
//   done       one-cycle pulse when GT/EQ/LT become valid
//   GT, EQ, LT registered result flags; held until the next accepted start
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             EQ,
  output logic             LT
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the chunk datapath never needs to know the mode.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [IDXW-1:0]  idx, idx_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic             gt_n, eq_n, lt_n;
  logic             load;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  int               base;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    gt_n    = GT;
    eq_n    = EQ;
    lt_n    = LT;
    load    = 1'b0;
    base    = int'(idx) * CHUNK;
    chunk_a = a_q[base +: CHUNK];
    chunk_b = b_q[base +: CHUNK];

    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          gt_n    = 1'b0;
          eq_n    = 1'b0;
          lt_n    = 1'b0;
          idx_n   = IDXW'(N - 1);
          state_n = COMPARE;
        end
      end

      COMPARE: begin
        if (chunk_a > chunk_b) begin
          gt_n    = 1'b1;
          state_n = DONE;
        end else if (chunk_a < chunk_b) begin
          lt_n    = 1'b1;
          state_n = DONE;
        end else if (idx == '0) begin
          // Every chunk matched all the way down to the LSB chunk.
          eq_n    = 1'b1;
          state_n = DONE;
        end else begin
          idx_n = idx - IDXW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      GT    <= 1'b0;
      EQ    <= 1'b0;
      LT    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      GT    <= gt_n;
      EQ    <= eq_n;
      LT    <= lt_n;
      if (load) begin
        // Operands are stored already sign-adjusted, so is_signed need not be kept.
        a_q <= A ^ (is_signed ? SIGN_MASK : '0);
        b_q <= B ^ (is_signed ? SIGN_MASK : '0);
      end
    end
  end

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

endmodule
